ex_mem_reg: RTL

- EX/MEM pipeline register directly downstream of the 32-bit LAC ALU (a, b, S, Cin → d, Cout, V).
- Captures the ALU result and flags together with the destination and memory control signals from the EX stage, and presents them to the MEM stage.
- Implements stall hold, flush bubble insertion, and a signed-overflow trap with EPC capture and a saturating trap counter.

---
 rtl/ex_mem_reg.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ex_mem_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg
//
// EX/MEM pipeline register sitting directly behind the 32-bit LAC ALU.
// It captures the ALU result and flags together with the destination and
// memory control bits of the EX instruction and presents them to MEM one
// cycle later. Signed-overflow trapping is also handled here: a trapping
// instruction is forwarded as a valid but side-effect-free slot, the first
// trap PC is latched into epc, and a saturating counter tallies every trap.
//
// Per-edge priority: flush > stall > load.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid               EX stage holds a valid instruction
//   stall, flush           hold outputs / insert a bubble this edge
//   alu_d, alu_cout, alu_v ALU result, carry out, signed overflow
//   alu_s                  ALU op select (010 add, 011 sub, others logic)
//   ovf_trap_en            overflow trapping enabled for this instruction
//   rd_addr, reg_write     destination register and writeback enable
//   mem_read, mem_write    load / store controls
//   store_data, pc         store operand and PC of the EX instruction
//   exc_ack                exception handler acknowledge
//   out_*                  registered MEM-stage copies of the above
//   exc_ovf                one-cycle pulse on a newly accepted trap
//   exc_pending            sticky trap flag, cleared by exc_ack
//   epc                    PC of the accepted trapping instruction
//   ovf_count              saturating count of all trap conditions
// ---------------------------------------------------------------------------
module ex_mem_reg #(
    parameter int WIDTH = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] alu_d,
    input  logic             alu_cout,
    input  logic             alu_v,
    input  logic [2:0]       alu_s,
    input  logic             ovf_trap_en,
    input  logic [RA_W-1:0]  rd_addr,
    input  logic             reg_write,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [WIDTH-1:0] store_data,
    input  logic [WIDTH-1:0] pc,
    input  logic             exc_ack,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_v,
    output logic [RA_W-1:0]  out_rd,
    output logic             out_reg_write,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic [WIDTH-1:0] out_store_data,
    output logic             exc_ovf,
    output logic             exc_pending,
    output logic [WIDTH-1:0] epc,
    output logic [CNT_W-1:0] ovf_count
);

    // Pipeline state
    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_v;
    logic [RA_W-1:0]  r_rd;
    logic             r_reg_write;
    logic             r_mem_read;
    logic             r_mem_write;
    logic [WIDTH-1:0] r_store_data;

    // Exception state
    logic             r_exc_ovf;
    logic             r_exc_pending;
    logic [WIDTH-1:0] r_epc;
    logic [CNT_W-1:0] r_ovf_count;

    // Decoded per-edge conditions
    logic w_is_arith;
    logic w_load;
    logic w_trap;
    logic w_accept;
    logic w_ctrl_ok;
    logic w_cnt_sat;

    // Only add and sub produce meaningful carry/overflow; a trap is only
    // considered on a real load edge so stalled or flushed instructions
    // never raise one. A new trap is accepted when nothing is pending, or
    // when the handler is acknowledging on this very edge (new trap wins).
    // Control bits of a trapping instruction are suppressed so that the
    // destination register and memory are never touched.
    always_comb begin
        w_is_arith = (alu_s == 3'b010) || (alu_s == 3'b011);
        w_load     = ~stall & ~flush;
        w_trap     = w_load & in_valid & ovf_trap_en & alu_v & w_is_arith;
        w_accept   = w_trap & (~r_exc_pending | exc_ack);
        w_ctrl_ok  = in_valid & ~w_trap;
        w_cnt_sat  = (r_ovf_count == {CNT_W{1'b1}});
    end

    // Pipeline register. A flush kills the valid and side-effect bits but
    // leaves the data fields alone; a stall freezes everything; otherwise
    // the EX stage values are captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_result     <= '0;
            r_cout       <= 1'b0;
            r_v          <= 1'b0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_store_data <= '0;
        end else if (flush) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else if (!stall) begin
            r_valid      <= in_valid;
            r_result     <= alu_d;
            r_cout       <= alu_cout & w_is_arith;
            r_v          <= alu_v & w_is_arith;
            r_rd         <= rd_addr;
            r_reg_write  <= reg_write & w_ctrl_ok;
            r_mem_read   <= mem_read & w_ctrl_ok;
            r_mem_write  <= mem_write & w_ctrl_ok;
            r_store_data <= store_data;
        end
    end

    // Exception tracking. The pulse is rebuilt every edge so it can only be
    // high for the single cycle following an accepted trap. The acknowledge
    // is honoured on every edge, including stalled and flushed ones, unless
    // a new trap is accepted at the same time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exc_ovf     <= 1'b0;
            r_exc_pending <= 1'b0;
            r_epc         <= '0;
            r_ovf_count   <= '0;
        end else begin
            r_exc_ovf <= w_accept;
            if (w_accept) begin
                r_exc_pending <= 1'b1;
                r_epc         <= pc;
            end else if (exc_ack) begin
                r_exc_pending <= 1'b0;
            end
            if (w_trap && !w_cnt_sat) begin
                r_ovf_count <= r_ovf_count + CNT_W'(1);
            end
        end
    end

    assign out_valid      = r_valid;
    assign out_result     = r_result;
    assign out_cout       = r_cout;
    assign out_v          = r_v;
    assign out_rd         = r_rd;
    assign out_reg_write  = r_reg_write;
    assign out_mem_read   = r_mem_read;
    assign out_mem_write  = r_mem_write;
    assign out_store_data = r_store_data;
    assign exc_ovf        = r_exc_ovf;
    assign exc_pending    = r_exc_pending;
    assign epc            = r_epc;
    assign ovf_count      = r_ovf_count;

endmodule
